// File: rtl/test_status_monitor_pkg.sv
// -----------------------------------------------------------------------------
// test_status_monitor_pkg
// Shared types and constants for the register-file writeback test monitor:
//   word_t       - 32-bit architectural word
//   regbits_t    - 5-bit register index
//   tsm_state_t  - monitor state (RUN / PASS / FAIL)
//   fail_code_t  - reason a test concluded without passing
// Also provides the default pass/fail signature words and a small helper that
// recognises the two shadowed registers (x30, x31).
// -----------------------------------------------------------------------------
package test_status_monitor_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } tsm_state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_SIG     = 2'd1,
    FC_TIMEOUT = 2'd2
  } fail_code_t;

  localparam word_t    DEF_PASS_SIG = 32'hBEEF_BEEF;
  localparam word_t    DEF_FAIL_SIG = 32'hDEAD_DEAD;
  localparam regbits_t REG_X30      = 5'd30;
  localparam regbits_t REG_X31      = 5'd31;

  // True when the index names one of the two shadowed result registers.
  function automatic logic is_shadow_reg(input regbits_t rd);
    return (rd == REG_X30) || (rd == REG_X31);
  endfunction

endpackage

// File: rtl/test_status_monitor_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset, clears the count
//   en    - count one this cycle
//   count - registered count value
// WIDTH must be at least 1.
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  // Count register: clears on reset, increments when enabled until saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {WIDTH{1'b0}};
    end else if (en && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/test_status_monitor.sv
// -----------------------------------------------------------------------------
// test_status_monitor
// Passive monitor on the core's register-file writeback port. It shadows x30
// and x31, and concludes the test when both hold the pass signature, when the
// fail signature is written to either, or when the run exceeds a cycle budget.
// Results are sticky until reset.
// Parameters:
//   TIMEOUT_CYCLES - RUN cycles allowed before a timeout fail (must be >= 1)
//   PASS_SIG       - value both x30 and x31 must hold to pass
//   FAIL_SIG       - any write of this value to x30/x31 fails immediately
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous active-high reset, clears all state
//   wb_en     - register-file write strobe
//   wb_rd     - destination register index
//   wb_data   - writeback value
//   retire    - one instruction retired this cycle
//   done      - test concluded (sticky)
//   pass      - concluded with pass (meaningful when done)
//   fail_code - FC_NONE / FC_SIG / FC_TIMEOUT, held from the transition
//   cycles    - RUN cycles, saturating
//   retired   - retire pulses seen in RUN, saturating
//   result    - current x31 shadow value
// -----------------------------------------------------------------------------
module test_status_monitor
  import test_status_monitor_pkg::*;
#(
  parameter int    TIMEOUT_CYCLES = 100000,
  parameter word_t PASS_SIG       = DEF_PASS_SIG,
  parameter word_t FAIL_SIG       = DEF_FAIL_SIG
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wb_en,
  input  regbits_t   wb_rd,
  input  word_t      wb_data,
  input  logic       retire,
  output logic       done,
  output logic       pass,
  output fail_code_t fail_code,
  output word_t      cycles,
  output word_t      retired,
  output word_t      result
);

  // The cycle counter is compared before its increment, so the last RUN edge
  // sees TIMEOUT_CYCLES-1 and leaves cycles == TIMEOUT_CYCLES afterwards.
  localparam word_t TIMEOUT_LAST = word_t'(TIMEOUT_CYCLES - 1);

  tsm_state_t r_state;
  word_t      r_x30;
  word_t      r_x31;
  logic       r_v30;
  logic       r_v31;
  logic       r_done;
  logic       r_pass;
  fail_code_t r_fail_code;

  tsm_state_t w_state_next;
  fail_code_t w_fc_next;
  word_t      w_x30_next;
  word_t      w_x31_next;
  logic       w_v30_next;
  logic       w_v31_next;
  logic       w_pass_hit;
  logic       w_sig_hit;
  logic       w_timeout_hit;
  logic       w_run;
  word_t      w_cycles;
  word_t      w_retired;

  assign w_run = (r_state == RUN);

  sat_counter #(.WIDTH(32)) u_cycles (
    .clk   (clk),
    .rst   (rst),
    .en    (w_run),
    .count (w_cycles)
  );

  sat_counter #(.WIDTH(32)) u_retired (
    .clk   (clk),
    .rst   (rst),
    .en    (w_run & retire),
    .count (w_retired)
  );

  // Next-state logic: shadow updates and verdict selection (pass > sig > timeout).
  always_comb begin
    w_state_next  = r_state;
    w_fc_next     = r_fail_code;
    w_x30_next    = r_x30;
    w_x31_next    = r_x31;
    w_v30_next    = r_v30;
    w_v31_next    = r_v31;
    w_pass_hit    = 1'b0;
    w_sig_hit     = 1'b0;
    w_timeout_hit = 1'b0;

    case (r_state)
      RUN: begin
        if (wb_en && (wb_rd == REG_X30)) begin
          w_x30_next = wb_data;
          w_v30_next = 1'b1;
        end else begin
          w_x30_next = r_x30;
          w_v30_next = r_v30;
        end

        if (wb_en && (wb_rd == REG_X31)) begin
          w_x31_next = wb_data;
          w_v31_next = 1'b1;
        end else begin
          w_x31_next = r_x31;
          w_v31_next = r_v31;
        end

        // Pass is judged on the post-write shadows so the completing write
        // counts in its own cycle, and a stale match is dropped on rewrite.
        w_pass_hit    = w_v30_next && w_v31_next &&
                        (w_x30_next == PASS_SIG) && (w_x31_next == PASS_SIG);
        w_sig_hit     = wb_en && is_shadow_reg(wb_rd) && (wb_data == FAIL_SIG);
        w_timeout_hit = (w_cycles == TIMEOUT_LAST);

        if (w_pass_hit) begin
          w_state_next = PASS;
          w_fc_next    = FC_NONE;
        end else if (w_sig_hit) begin
          w_state_next = FAIL;
          w_fc_next    = FC_SIG;
        end else if (w_timeout_hit) begin
          w_state_next = FAIL;
          w_fc_next    = FC_TIMEOUT;
        end else begin
          w_state_next = RUN;
          w_fc_next    = FC_NONE;
        end
      end

      PASS, FAIL: begin
        // Absorbing: shadows and verdict are frozen until reset.
        w_state_next = r_state;
        w_fc_next    = r_fail_code;
      end

      default: begin
        // Unreachable encoding: conclude so a waiting bench does not hang.
        w_state_next = FAIL;
        w_fc_next    = r_fail_code;
      end
    endcase
  end

  // State, shadow and registered-output update; reset wins over any event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_x30       <= 32'h0000_0000;
      r_x31       <= 32'h0000_0000;
      r_v30       <= 1'b0;
      r_v31       <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_code <= FC_NONE;
    end else begin
      r_state     <= w_state_next;
      r_x30       <= w_x30_next;
      r_x31       <= w_x31_next;
      r_v30       <= w_v30_next;
      r_v31       <= w_v31_next;
      r_done      <= (w_state_next != RUN);
      r_pass      <= (w_state_next == PASS);
      r_fail_code <= w_fc_next;
    end
  end

  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_code = r_fail_code;
  assign cycles    = w_cycles;
  assign retired   = w_retired;
  assign result    = r_x31;

endmodule

// File: tb/tb_test_status_monitor.sv
// -----------------------------------------------------------------------------
// tb_test_status_monitor
// Directed stimulus with hand-computed expectations pushed into a scoreboard,
// tagged with the bench cycle at which they must hold; an independent monitor
// compares DUT outputs on every falling edge.
// -----------------------------------------------------------------------------
module tb_test_status_monitor;
  import test_status_monitor_pkg::*;

  localparam int TO = 1000;
  localparam logic [31:0] PSIG = 32'hBEEF_BEEF;
  localparam logic [31:0] FSIG = 32'hDEAD_DEAD;

  logic        clk;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        retire;
  logic        done_o;
  logic        pass_o;
  fail_code_t  fc_o;
  logic [31:0] cycles_o;
  logic [31:0] retired_o;
  logic [31:0] result_o;

  logic        sat_rst;
  logic        sat_en;
  logic [2:0]  sat_cnt;

  int cyc;
  int checks;
  int errors;

  typedef struct {
    int          at;
    string       name;
    int          kind;   // 0: verdict outputs, 1: counters, 2: small saturating counter
    logic        done_v;
    logic        pass_v;
    logic [1:0]  fc_v;
    logic [31:0] res_v;
    logic [31:0] cyc_v;
    logic [31:0] ret_v;
    logic [2:0]  sat_v;
  } exp_t;

  exp_t sb_q[$];
  exp_t rest_q[$];

  test_status_monitor #(
    .TIMEOUT_CYCLES (TO),
    .PASS_SIG       (PSIG),
    .FAIL_SIG       (FSIG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .retire    (retire),
    .done      (done_o),
    .pass      (pass_o),
    .fail_code (fc_o),
    .cycles    (cycles_o),
    .retired   (retired_o),
    .result    (result_o)
  );

  sat_counter #(.WIDTH(3)) u_sat (
    .clk   (clk),
    .rst   (sat_rst),
    .en    (sat_en),
    .count (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_main(input int ofs, input string nm, input logic d, input logic p,
                           input logic [1:0] f, input logic [31:0] r);
    exp_t e;
    e.at = cyc + ofs; e.name = nm; e.kind = 0;
    e.done_v = d; e.pass_v = p; e.fc_v = f; e.res_v = r;
    e.cyc_v = 32'h0; e.ret_v = 32'h0; e.sat_v = 3'd0;
    sb_q.push_back(e);
  endtask

  task automatic push_cnt(input int ofs, input string nm, input logic [31:0] c, input logic [31:0] r);
    exp_t e;
    e.at = cyc + ofs; e.name = nm; e.kind = 1;
    e.done_v = 1'b0; e.pass_v = 1'b0; e.fc_v = 2'd0; e.res_v = 32'h0;
    e.cyc_v = c; e.ret_v = r; e.sat_v = 3'd0;
    sb_q.push_back(e);
  endtask

  task automatic push_sat(input int ofs, input string nm, input logic [2:0] v);
    exp_t e;
    e.at = cyc + ofs; e.name = nm; e.kind = 2;
    e.done_v = 1'b0; e.pass_v = 1'b0; e.fc_v = 2'd0; e.res_v = 32'h0;
    e.cyc_v = 32'h0; e.ret_v = 32'h0; e.sat_v = v;
    sb_q.push_back(e);
  endtask

  // Hold reset n cycles, expecting reset values after every reset edge.
  task automatic do_reset(input int n);
    rst = 1'b1; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; retire = 1'b0;
    for (int k = 1; k <= n; k++) begin
      push_main(k, "reset", 1'b0, 1'b0, 2'd0, 32'h0);
      push_cnt(k, "reset", 32'd0, 32'd0);
    end
    step(n);
    rst = 1'b0;
  endtask

  // One-cycle write with the verdict expected right after it.
  task automatic wr(input logic [4:0] rd, input logic [31:0] d, input string nm,
                    input logic ed, input logic ep, input logic [1:0] ef, input logic [31:0] er);
    wb_en = 1'b1; wb_rd = rd; wb_data = d;
    push_main(1, nm, ed, ep, ef, er);
    step(1);
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
  endtask

  // Monitor: compares every scoreboard entry due this cycle; late entries fail.
  initial begin
    forever begin
      @(negedge clk);
      rest_q.delete();
      foreach (sb_q[i]) begin
        if (sb_q[i].at == cyc) begin
          case (sb_q[i].kind)
            0: begin
              chk({sb_q[i].name, ".done"},      32'(done_o),   32'(sb_q[i].done_v));
              chk({sb_q[i].name, ".pass"},      32'(pass_o),   32'(sb_q[i].pass_v));
              chk({sb_q[i].name, ".fail_code"}, 32'(fc_o),     32'(sb_q[i].fc_v));
              chk({sb_q[i].name, ".result"},    result_o,      sb_q[i].res_v);
            end
            1: begin
              chk({sb_q[i].name, ".cycles"},    cycles_o,      sb_q[i].cyc_v);
              chk({sb_q[i].name, ".retired"},   retired_o,     sb_q[i].ret_v);
            end
            default: begin
              chk({sb_q[i].name, ".sat"},       32'(sat_cnt),  32'(sb_q[i].sat_v));
            end
          endcase
        end else if (sb_q[i].at < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s: missed, due cycle %0d, now %0d", sb_q[i].name, sb_q[i].at, cyc);
        end else begin
          rest_q.push_back(sb_q[i]);
        end
      end
      sb_q = rest_q;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected finish");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    cyc = 0; checks = 0; errors = 0;
    rst = 1'b1; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; retire = 1'b0;
    sat_rst = 1'b1; sat_en = 1'b0;
    step(1);

    // Reset, then timeout with no writes.
    do_reset(3);
    push_main(999,  "to_pre",  1'b0, 1'b0, 2'd0, 32'h0);
    push_cnt (999,  "to_pre",  32'd999, 32'd0);
    push_main(1000, "to_hit",  1'b1, 1'b0, 2'd2, 32'h0);
    push_cnt (1000, "to_hit",  32'd1000, 32'd0);
    push_main(1005, "to_hold", 1'b1, 1'b0, 2'd2, 32'h0);
    push_cnt (1005, "to_hold", 32'd1000, 32'd0);
    step(1006);

    // Pass: x30, 5 idle, x31; later write ignored.
    do_reset(1);
    wr(5'd30, PSIG, "pass_x30", 1'b0, 1'b0, 2'd0, 32'h0);
    step(5);
    push_cnt(1, "pass_hit", 32'd7, 32'd0);
    wr(5'd31, PSIG, "pass_hit", 1'b1, 1'b1, 2'd0, PSIG);
    push_cnt(1, "pass_frozen", 32'd7, 32'd0);
    wr(5'd30, 32'h0, "pass_frozen", 1'b1, 1'b1, 2'd0, PSIG);

    // Partial match and overwrite.
    do_reset(1);
    wr(5'd30, PSIG,         "ovr_x30a", 1'b0, 1'b0, 2'd0, 32'h0);
    wr(5'd30, 32'h0000_0001, "ovr_x30b", 1'b0, 1'b0, 2'd0, 32'h0);
    wr(5'd31, PSIG,         "ovr_x31",  1'b0, 1'b0, 2'd0, PSIG);
    wr(5'd30, PSIG,         "ovr_pass", 1'b1, 1'b1, 2'd0, PSIG);

    // Signature fail; other indices and disabled strobes ignored.
    do_reset(1);
    wr(5'd0,  FSIG, "sig_x0",  1'b0, 1'b0, 2'd0, 32'h0);
    wr(5'd29, FSIG, "sig_x29", 1'b0, 1'b0, 2'd0, 32'h0);
    wb_en = 1'b0; wb_rd = 5'd31; wb_data = FSIG;
    push_main(1, "sig_noen", 1'b0, 1'b0, 2'd0, 32'h0);
    step(1);
    wr(5'd31, FSIG, "sig_hit",    1'b1, 1'b0, 2'd1, FSIG);
    wr(5'd30, PSIG, "sig_hold30", 1'b1, 1'b0, 2'd1, FSIG);
    wr(5'd31, PSIG, "sig_hold31", 1'b1, 1'b0, 2'd1, FSIG);

    // Completing pass write on the timeout edge.
    do_reset(1);
    wr(5'd30, PSIG, "tp_x30", 1'b0, 1'b0, 2'd0, 32'h0);
    push_main(998, "tp_pre", 1'b0, 1'b0, 2'd0, 32'h0);
    push_cnt (998, "tp_pre", 32'd999, 32'd0);
    step(998);
    push_cnt(1, "tp_hit", 32'd1000, 32'd0);
    wr(5'd31, PSIG, "tp_hit", 1'b1, 1'b1, 2'd0, PSIG);

    // Fail signature on the timeout edge.
    do_reset(1);
    push_main(999, "ts_pre", 1'b0, 1'b0, 2'd0, 32'h0);
    push_cnt (999, "ts_pre", 32'd999, 32'd0);
    step(999);
    wr(5'd30, FSIG, "ts_hit", 1'b1, 1'b0, 2'd1, 32'h0);

    // Reset together with a completing write.
    do_reset(1);
    wr(5'd30, PSIG, "rw_x30", 1'b0, 1'b0, 2'd0, 32'h0);
    rst = 1'b1; wb_en = 1'b1; wb_rd = 5'd31; wb_data = PSIG;
    push_main(1, "rw_rst", 1'b0, 1'b0, 2'd0, 32'h0);
    push_cnt (1, "rw_rst", 32'd0, 32'd0);
    step(1);
    rst = 1'b0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    push_main(3, "rw_idle", 1'b0, 1'b0, 2'd0, 32'h0);
    step(3);
    wr(5'd31, PSIG, "rw_x31only", 1'b0, 1'b0, 2'd0, PSIG);

    // Retire counting: 10 pulses over 20 cycles.
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      retire = (i % 2 == 0);
      step(1);
    end
    retire = 1'b0;
    push_cnt(1, "retire", 32'd21, 32'd10);
    step(2);

    // Saturation on a narrow instance of the counter.
    sat_rst = 1'b1; sat_en = 1'b0;
    push_sat(1, "sat_rst", 3'd0);
    step(1);
    sat_rst = 1'b0; sat_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      push_sat(k, $sformatf("sat_%0d", k), (k < 7) ? 3'(k) : 3'd7);
    end
    step(10);
    sat_en = 1'b0;
    push_sat(2, "sat_hold", 3'd7);
    step(3);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
